// File: rtl/nf_hz_stall_ctrl_pkg.sv
// Shared types and defaults for the nanoFOX hazard stall/flush controller.
package nf_hz_stall_ctrl_pkg;

  // Bus-wait FSM states, shared by the data and instruction ports.
  typedef enum logic [1:0] {BW_IDLE, BW_WAIT, BW_ERR} nf_bus_wait_t;

  localparam int unsigned NF_DM_TIMEOUT = 255;
  localparam int unsigned NF_I_TIMEOUT  = 255;

  // Wait counter width; at least one bit even when the timeout is disabled.
  function automatic int unsigned bw_cnt_w(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/nf_bus_wait_fsm.sv
// Bus-wait tracker: stalls while a request is unacknowledged and raises a
// one-cycle error once the wait reaches TIMEOUT cycles (0 = never time out).
module nf_bus_wait_fsm
  import nf_hz_stall_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = NF_DM_TIMEOUT
) (
  input  logic clk,
  input  logic resetn,
  input  logic req,
  input  logic ack,
  output logic wait_stall,
  output logic err
);

  localparam int unsigned   CntW   = bw_cnt_w(TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  nf_bus_wait_t    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // State and wait counter; reset drops any pending wait silently.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= BW_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: an ack in the timeout cycle wins over the error.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      BW_IDLE: begin
        if (req && !ack) begin
          state_d = BW_WAIT;
          cnt_d   = CntW'(1);
        end
      end
      BW_WAIT: begin
        if (ack || !req) begin
          state_d = BW_IDLE;
          cnt_d   = '0;
        end else if ((TIMEOUT != 0) && (cnt_q == CntMax)) begin
          state_d = BW_ERR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      BW_ERR: begin
        state_d = BW_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = BW_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The error cycle releases the stall so the pipeline can flush and move on.
  assign wait_stall = resetn & req & ~ack & (state_q != BW_ERR);
  assign err        = (state_q == BW_ERR);

endmodule

// File: rtl/nf_hz_stall_ctrl.sv
// Hazard stall/flush controller for the nanoFOX 5-stage pipeline.
// Optional saturating stall-cycle counter: define NF_HZ_STALL_CNT_EN.
module nf_hz_stall_ctrl
  import nf_hz_stall_ctrl_pkg::*;
#(
  parameter int unsigned NUM_RA     = 2,
  parameter int unsigned RA_W       = 5,
  parameter int unsigned DM_TIMEOUT = NF_DM_TIMEOUT,
  parameter int unsigned I_TIMEOUT  = NF_I_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_RA*RA_W-1:0] ra_id,
  input  logic [NUM_RA-1:0]      ra_used_id,
  input  logic                   branch_id,
  input  logic [RA_W-1:0]        wa3_iexe,
  input  logic                   we_rf_iexe,
  input  logic                   rf_src_iexe,
  input  logic [RA_W-1:0]        wa3_imem,
  input  logic                   we_rf_imem,
  input  logic                   rf_src_imem,
  input  logic                   req_dm_imem,
  input  logic                   req_ack_dm,
  input  logic                   req_i,
  input  logic                   req_ack_i,
  output logic                   stall_if,
  output logic                   stall_id,
  output logic                   stall_iexe,
  output logic                   stall_imem,
  output logic                   stall_iwb,
  output logic                   flush_iexe,
  output logic                   dm_err,
  output logic                   i_err,
  output logic [31:0]            stall_cnt
);

  logic any_e, any_m_ld, lu, br, hz;
  logic dm_stall, if_stall;

  // Read-port matches against EXE (any writer) and MEM (loads only).
  always_comb begin
    any_e    = 1'b0;
    any_m_ld = 1'b0;
    for (int k = 0; k < NUM_RA; k++) begin
      if (ra_used_id[k] && (ra_id[k*RA_W +: RA_W] == wa3_iexe) &&
          (wa3_iexe != '0) && we_rf_iexe) begin
        any_e = 1'b1;
      end
      if (ra_used_id[k] && (ra_id[k*RA_W +: RA_W] == wa3_imem) &&
          (wa3_imem != '0) && we_rf_imem && rf_src_imem) begin
        any_m_ld = 1'b1;
      end
    end
  end

  assign lu = any_e & rf_src_iexe;
  assign br = branch_id & (any_e | any_m_ld);
  assign hz = resetn & (lu | br);

  nf_bus_wait_fsm #(
    .TIMEOUT (DM_TIMEOUT)
  ) u_dm_wait (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req_dm_imem),
    .ack        (req_ack_dm),
    .wait_stall (dm_stall),
    .err        (dm_err)
  );

  nf_bus_wait_fsm #(
    .TIMEOUT (I_TIMEOUT)
  ) u_i_wait (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req_i),
    .ack        (req_ack_i),
    .wait_stall (if_stall),
    .err        (i_err)
  );

  // A data-bus stall freezes the back end, so EXE is held rather than flushed.
  always_comb begin
    stall_if   = hz | dm_stall | if_stall;
    stall_id   = stall_if;
    stall_iexe = dm_stall;
    stall_imem = dm_stall;
    stall_iwb  = dm_stall;
    flush_iexe = ((hz | if_stall) & ~dm_stall) | dm_err | i_err;
  end

`ifdef NF_HZ_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of front-end stall cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
    end else if (stall_if && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_nf_hz_stall_ctrl.sv
// Self-checking bench for nf_hz_stall_ctrl with short bus timeouts.
module tb_nf_hz_stall_ctrl;

  localparam int unsigned NUM_RA = 2;
  localparam int unsigned RA_W   = 5;

  // Output vector: {stall_if, stall_id, stall_iexe, stall_imem, stall_iwb,
  //                 flush_iexe, dm_err, i_err}
  localparam logic [7:0] V_NONE = 8'b0000_0000;
  localparam logic [7:0] V_FE   = 8'b1100_0100;  // front-end stall + EXE bubble
  localparam logic [7:0] V_DM   = 8'b1111_1000;  // full data-bus stall
  localparam logic [7:0] V_DERR = 8'b0000_0110;
  localparam logic [7:0] V_IERR = 8'b0000_0101;

  logic                   clk, resetn;
  logic [NUM_RA*RA_W-1:0] ra_id;
  logic [NUM_RA-1:0]      ra_used_id;
  logic                   branch_id;
  logic [RA_W-1:0]        wa3_iexe, wa3_imem;
  logic                   we_rf_iexe, rf_src_iexe, we_rf_imem, rf_src_imem;
  logic                   req_dm_imem, req_ack_dm, req_i, req_ack_i;
  logic                   stall_if, stall_id, stall_iexe, stall_imem, stall_iwb;
  logic                   flush_iexe, dm_err, i_err;
  logic [31:0]            stall_cnt;
  logic [7:0]             outs;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;
  exp_t sb[$];

  nf_hz_stall_ctrl #(
    .NUM_RA     (NUM_RA),
    .RA_W       (RA_W),
    .DM_TIMEOUT (4),
    .I_TIMEOUT  (6)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ra_id       (ra_id),
    .ra_used_id  (ra_used_id),
    .branch_id   (branch_id),
    .wa3_iexe    (wa3_iexe),
    .we_rf_iexe  (we_rf_iexe),
    .rf_src_iexe (rf_src_iexe),
    .wa3_imem    (wa3_imem),
    .we_rf_imem  (we_rf_imem),
    .rf_src_imem (rf_src_imem),
    .req_dm_imem (req_dm_imem),
    .req_ack_dm  (req_ack_dm),
    .req_i       (req_i),
    .req_ack_i   (req_ack_i),
    .stall_if    (stall_if),
    .stall_id    (stall_id),
    .stall_iexe  (stall_iexe),
    .stall_imem  (stall_imem),
    .stall_iwb   (stall_iwb),
    .flush_iexe  (flush_iexe),
    .dm_err      (dm_err),
    .i_err       (i_err),
    .stall_cnt   (stall_cnt)
  );

  assign outs = {stall_if, stall_id, stall_iexe, stall_imem, stall_iwb,
                 flush_iexe, dm_err, i_err};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Push the expected outputs for the inputs just driven, compare at negedge,
  // then advance to just after the next rising edge.
  task automatic step(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check_eq(e.tag, {24'd0, outs}, {24'd0, e.v});
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    ra_id       = '0;
    ra_used_id  = '0;
    branch_id   = 1'b0;
    wa3_iexe    = '0;
    we_rf_iexe  = 1'b0;
    rf_src_iexe = 1'b0;
    wa3_imem    = '0;
    we_rf_imem  = 1'b0;
    rf_src_imem = 1'b0;
    req_dm_imem = 1'b0;
    req_ack_dm  = 1'b0;
    req_i       = 1'b0;
    req_ack_i   = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    clr_in();
    @(posedge clk);
    #1;

    // Reset gates everything, even with requests pending.
    req_dm_imem = 1'b1;
    req_i       = 1'b1;
    step("rst_gate", V_NONE);
    check_eq("rst_cnt", stall_cnt, 32'd0);
    clr_in();
    resetn = 1'b1;
    step("idle", V_NONE);

    // Load-use on port 1.
    wa3_iexe = 5'd5; we_rf_iexe = 1'b1; rf_src_iexe = 1'b1;
    ra_id = {5'd5, 5'd0}; ra_used_id = 2'b10;
    step("lu_p1", V_FE);
    wa3_iexe = 5'd0; ra_id = {5'd0, 5'd0};
    step("lu_x0", V_NONE);
    wa3_iexe = 5'd5; ra_id = {5'd5, 5'd0}; ra_used_id = 2'b00;
    step("lu_unused", V_NONE);
    ra_used_id = 2'b10; rf_src_iexe = 1'b0;
    step("alu_no_br", V_NONE);
    clr_in();

    // Branch against MEM load and EXE ALU result.
    branch_id = 1'b1; wa3_imem = 5'd7; we_rf_imem = 1'b1; rf_src_imem = 1'b1;
    ra_id = {5'd0, 5'd7}; ra_used_id = 2'b01;
    step("br_mem_ld", V_FE);
    rf_src_imem = 1'b0;
    step("br_mem_alu", V_NONE);
    we_rf_imem = 1'b0; wa3_iexe = 5'd7; we_rf_iexe = 1'b1;
    step("br_exe_alu", V_FE);
    clr_in();

    // Data wait: three stall cycles, then ack.
    req_dm_imem = 1'b1;
    repeat (3) step("dm_wait", V_DM);
    req_ack_dm = 1'b1;
    step("dm_ack", V_NONE);
    req_ack_dm = 1'b0;
    step("dm_new_req", V_DM);
    req_ack_dm = 1'b1;
    step("dm_ack2", V_NONE);
    clr_in();
    step("dm_idle", V_NONE);

    // Data timeout of 4: IDLE plus four WAIT cycles, error, then repeat.
    req_dm_imem = 1'b1;
    repeat (5) step("dm_to_wait", V_DM);
    step("dm_to_err", V_DERR);
    step("dm_to_again", V_DM);
    req_ack_dm = 1'b1;
    step("dm_to_ack", V_NONE);
    clr_in();
    step("dm_to_idle", V_NONE);

    // Ack in the timeout cycle wins.
    req_dm_imem = 1'b1;
    repeat (4) step("dm_race_wait", V_DM);
    req_ack_dm = 1'b1;
    step("dm_race_ack", V_NONE);
    req_ack_dm = 1'b0;
    step("dm_race_noerr", V_DM);
    clr_in();
    step("dm_race_idle", V_NONE);

    // Instruction timeout of 6.
    req_i = 1'b1;
    repeat (7) step("i_to_wait", V_FE);
    step("i_to_err", V_IERR);
    clr_in();
    step("i_to_idle", V_NONE);

    // Fetch and data stall together: EXE held, not flushed.
    req_i = 1'b1; req_dm_imem = 1'b1;
    wa3_iexe = 5'd5; we_rf_iexe = 1'b1; rf_src_iexe = 1'b1;
    ra_id = {5'd5, 5'd0}; ra_used_id = 2'b10;
    step("sim_if_dm", V_DM);
    clr_in();
    step("sim_idle", V_NONE);

    // Reset in the middle of a data wait.
    req_dm_imem = 1'b1;
    repeat (2) step("rst_mid_wait", V_DM);
    resetn = 1'b0;
    step("rst_mid_out", V_NONE);
    resetn = 1'b1;
    clr_in();
    repeat (3) step("rst_mid_noerr", V_NONE);

`ifdef NF_HZ_STALL_CNT_EN
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    wa3_iexe = 5'd5; we_rf_iexe = 1'b1; rf_src_iexe = 1'b1;
    ra_id = {5'd5, 5'd0}; ra_used_id = 2'b10;
    repeat (10) step("cnt_stall", V_FE);
    clr_in();
    @(negedge clk);
    check_eq("cnt_10", stall_cnt, 32'd10);
    @(posedge clk);
    #1;
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    wa3_iexe = 5'd5; we_rf_iexe = 1'b1; rf_src_iexe = 1'b1;
    ra_id = {5'd5, 5'd0}; ra_used_id = 2'b10;
    repeat (5) step("cnt_sat_stall", V_FE);
    clr_in();
    @(negedge clk);
    check_eq("cnt_sat", stall_cnt, 32'hFFFF_FFFF);
`else
    @(negedge clk);
    check_eq("cnt_off", stall_cnt, 32'd0);
`endif

    check_eq("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nf_hz_stall_ctrl.md
Name: nf_hz_stall_ctrl

Overview:
Parametrised hazard stall/flush controller for the nanoFOX 5-stage pipeline, successor to the purely combinational stall unit.
- Adds N decode read ports with per-port "used" qualifiers.
- Adds load-to-branch detection against both EXE and MEM.
- Adds independent bus-wait FSMs with timeout counters for the data and instruction ports. A hung bus raises a one-cycle error instead of stalling forever.
- Sits beside nf_hz_fwd_unit inside the hazard block and drives all stage stall/flush enables.

Parameters:
NUM_RA, 2, number of decode-stage register read ports (1..4)
RA_W, 5, register address width
DM_TIMEOUT, 255, data-bus wait cycles before timeout error; 0 disables timeout
I_TIMEOUT, 255, instruction-bus wait cycles before timeout error; 0 disables timeout

Ports:
clk  in  1  core clock, rising edge
resetn  in  1  asynchronous active-low reset
ra_id  in  NUM_RA*RA_W  decode read addresses, port k at [k*RA_W +: RA_W]
ra_used_id  in  NUM_RA  port k actually read by the decode instruction
branch_id  in  1  decode instruction is a branch resolved in ID
wa3_iexe  in  RA_W  EXE destination register
we_rf_iexe  in  1  EXE writes register file
rf_src_iexe  in  1  EXE result comes from data memory (load)
wa3_imem  in  RA_W  MEM destination register
we_rf_imem  in  1  MEM writes register file
rf_src_imem  in  1  MEM result comes from data memory
req_dm_imem  in  1  MEM stage has an active data request (load or store)
req_ack_dm  in  1  data request acknowledge
req_i  in  1  fetch request active
req_ack_i  in  1  instruction request acknowledge
stall_if, stall_id, stall_iexe, stall_imem, stall_iwb  out  1 each  stage stall enables
flush_iexe  out  1  inject bubble into EXE
dm_err  out  1  one-cycle data-bus timeout pulse
i_err  out  1  one-cycle instruction-bus timeout pulse
stall_cnt  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Match rule: match_E(k) = ra_used_id[k] & (ra[k]==wa3_iexe) & (wa3_iexe!=0) & we_rf_iexe. match_M(k) is the same against the MEM signals.
- lu = OR_k match_E(k) & rf_src_iexe. This is load-use.
- br = branch_id & OR_k ( match_E(k) | (match_M(k) & rf_src_imem) ).
- DM FSM states: DM_IDLE, DM_WAIT, DM_ERR. Counter dm_cnt has width $clog2(DM_TIMEOUT+1), minimum 1.
  - IDLE -> WAIT when req_dm_imem & ~req_ack_dm; dm_cnt<=1.
  - WAIT: if req_ack_dm or ~req_dm_imem -> IDLE, dm_cnt<=0. Else if DM_TIMEOUT!=0 and dm_cnt==DM_TIMEOUT -> ERR. Else dm_cnt++.
  - ERR -> IDLE unconditionally after one cycle.
- dm_stall = req_dm_imem & ~req_ack_dm & (state!=DM_ERR).
- IF FSM: identical structure (I_IDLE/I_WAIT/I_ERR, i_cnt, I_TIMEOUT) on req_i/req_ack_i. if_stall = req_i & ~req_ack_i & (state!=I_ERR).
- dm_err = (dm_state==DM_ERR); i_err = (i_state==I_ERR). Each is registered state decode and pulses exactly 1 cycle.
- Outputs, all combinational from inputs and state:
  - stall_if = stall_id = lu | br | dm_stall | if_stall.
  - stall_iexe = stall_imem = stall_iwb = dm_stall.
  - flush_iexe = ((lu | br | if_stall) & ~dm_stall) | dm_err | i_err.
- Simultaneous events:
  - dm_stall has priority over flush of EXE; the EXE instruction is held, not killed.
  - An ack arriving in the same cycle the counter hits the timeout wins: the FSM returns to IDLE and no error is raised.
- Reset: async; both FSMs go to IDLE, counters to 0, stall_cnt to 0. Resetting mid-wait drops the pending wait with no error pulse.
- With resetn low, all outputs are 0 because req inputs are ignored. This holds even for the combinational outputs: every output is gated by resetn.

Optional Feature:
NF_HZ_STALL_CNT_EN
- Defined: stall_cnt increments by 1 on every clock where stall_if=1, saturating at 32'hFFFF_FFFF.
- Undefined: no counter logic is built and stall_cnt is tied to 0. The port is always present.

Decomposition:
- nf_hazard_unit.svh (shared package) gets:
  - typedef enum logic [1:0] nf_bus_wait_t {BW_IDLE, BW_WAIT, BW_ERR}
  - localparam defaults for NF_DM_TIMEOUT and NF_I_TIMEOUT.
- Sub-module nf_bus_wait_fsm (params TIMEOUT; ports clk, resetn, req, ack, wait_stall, err) is instantiated twice, once for the data port and once for the instruction port.

Test Plan:
- Load-use: EXE has load x5 (we_rf=1, rf_src=1), ID reads x5 on port 1 with used=1 -> stall_if=stall_id=flush_iexe=1, stall_iexe=0. Same case with wa3=x0 or used=0 -> all stall/flush outputs 0.
- Branch on MEM load: branch_id=1, MEM load to x7, ID ra0=x7 used -> stall_if=1, flush_iexe=1. Same with rf_src_imem=0 -> no stall.
- DM wait: req_dm_imem=1, ack low 3 cycles then high, DM_TIMEOUT=255 -> stall_iexe/imem/iwb=1 for exactly 3 cycles, dm_err never set, FSM back in IDLE.
- DM timeout: DM_TIMEOUT=4, ack never arrives -> 5 stall cycles (IDLE + 4 WAIT counts), then dm_err=1 and flush_iexe=1 for 1 cycle with stalls low, then the sequence repeats. Ack on the 4th WAIT cycle -> no err.
- Simultaneous: if_stall and dm_stall together -> stall_iexe=1, flush_iexe=0. Reset asserted mid-WAIT -> outputs 0 immediately, no err after release.
- Perf counter (NF_HZ_STALL_CNT_EN): 10 stall cycles -> stall_cnt=10. Preload near max via force -> saturates at FFFF_FFFF. Without the macro -> stall_cnt=0 always.
